// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade player-input front end:
// button bit positions, PS/2 scancodes and ioctl indices.
package arcade_input_pkg;

  localparam int NBTN     = 11;
  localparam int BTN_R    = 0;
  localparam int BTN_L    = 1;
  localparam int BTN_D    = 2;
  localparam int BTN_U    = 3;
  localparam int BTN_A    = 4;
  localparam int BTN_B    = 5;
  localparam int BTN_C    = 6;
  localparam int BTN_D2   = 7;
  localparam int BTN_S1   = 8;
  localparam int BTN_S2   = 9;
  localparam int BTN_COIN = 10;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_FA    = 8'h14;
  localparam logic [7:0] SC_FB    = 8'h11;
  localparam logic [7:0] SC_FC    = 8'h29;
  localparam logic [7:0] SC_FD    = 8'h12;
  localparam logic [7:0] SC_S1A   = 8'h05;
  localparam logic [7:0] SC_S1B   = 8'h16;
  localparam logic [7:0] SC_S2A   = 8'h06;
  localparam logic [7:0] SC_S2B   = 8'h1E;
  localparam logic [7:0] SC_COINA = 8'h2E;
  localparam logic [7:0] SC_COINB = 8'h36;

  localparam logic [7:0] IDX_DIP = 8'd254;
  localparam logic [7:0] IDX_MOD = 8'd1;

  // One-hot button mask for a scancode; zero when the key is unmapped.
  function automatic logic [NBTN-1:0] key_mask(input logic [7:0] code);
    key_mask = '0;
    unique case (1'b1)
      code == SC_UP:    key_mask[BTN_U]    = 1'b1;
      code == SC_DOWN:  key_mask[BTN_D]    = 1'b1;
      code == SC_LEFT:  key_mask[BTN_L]    = 1'b1;
      code == SC_RIGHT: key_mask[BTN_R]    = 1'b1;
      code == SC_FA:    key_mask[BTN_A]    = 1'b1;
      code == SC_FB:    key_mask[BTN_B]    = 1'b1;
      code == SC_FC:    key_mask[BTN_C]    = 1'b1;
      code == SC_FD:    key_mask[BTN_D2]   = 1'b1;
      code == SC_S1A,
      code == SC_S1B:   key_mask[BTN_S1]   = 1'b1;
      code == SC_S2A,
      code == SC_S2B:   key_mask[BTN_S2]   = 1'b1;
      code == SC_COINA,
      code == SC_COINB: key_mask[BTN_COIN] = 1'b1;
      default:          key_mask = '0;
    endcase
  endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_stretch.sv
// Single coin channel: rising-edge detect and fixed-length
// stretch; edges seen while the pulse is running are dropped.
module coin_stretch
  import arcade_input_pkg::*;
#(
  parameter int COIN_HOLD = 2_500_000
) (
  input  logic clk_sys,
  input  logic RESET_L,
  input  logic coin_in,
  output logic coin_out
);

  localparam int CW = (COIN_HOLD > 1) ? $clog2(COIN_HOLD) : 1;

  logic          prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (!RESET_L) begin
      prev     <= 1'b0;
      cnt      <= '0;
      coin_out <= 1'b0;
    end else begin
      prev <= coin_in;
      if (coin_in && !prev && !coin_out) begin
        cnt      <= CW'(COIN_HOLD - 1);
        coin_out <= 1'b1;
      end else if (coin_out) begin
        if (cnt == '0) coin_out <= 1'b0;
        else           cnt      <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Player-input front end: joystick source merge, PS/2 keys,
// coin stretching, OSD DIP banks and game-select byte.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int PLAYERS   = 2,
  parameter int DIP_BANKS = 8,
  parameter int COIN_HOLD = 2_500_000
) (
  input  logic                           clk_sys,
  input  logic                           RESET_L,
  input  logic [10:0]                    ps2_key,
  input  logic [16*PLAYERS-1:0]          joy_usb,
  input  logic [16*PLAYERS-1:0]          joy_db,
  input  logic [$clog2(PLAYERS+1)-1:0]   db_count,
  input  logic                           ioctl_wr,
  input  logic [7:0]                     ioctl_index,
  input  logic [24:0]                    ioctl_addr,
  input  logic [7:0]                     ioctl_dout,
  output logic [16*PLAYERS-1:0]          player_out,
  output logic [PLAYERS-1:0]             coin_out,
  output logic [8*DIP_BANKS-1:0]         dip_out,
  output logic [7:0]                     mod_id,
  output logic                           osd_req
);

  localparam int AW = $clog2(DIP_BANKS);

  logic [NBTN-1:0]         keys;
  logic [NBTN-1:0]         kmask;
  logic                    old_tog;
  logic [16*PLAYERS-1:0]   merged;
  logic [NBTN-1:0]         v;
  int                      dbc;
  logic [8*DIP_BANKS-1:0]  dip_q = '0;
  logic [7:0]              mod_q = '0;
  logic                    unused_in;

  assign unused_in = ^{ps2_key[8], joy_usb, joy_db};
  assign kmask     = key_mask(ps2_key[7:0]);

  always_comb begin
    merged = '0;
    v      = '0;
    dbc    = (int'(db_count) > PLAYERS) ? PLAYERS : int'(db_count);
    for (int p = 0; p < PLAYERS; p++) begin
      if (p < dbc) v = joy_db[16*p +: NBTN];
      else         v = joy_usb[16*(p-dbc) +: NBTN];
      if (p == 0) v = v | keys;
      merged[16*p +: 16] = {5'b0, v};
    end
  end

  // old_tog tracks the line during reset so release makes no event.
  always_ff @(posedge clk_sys) begin
    if (!RESET_L) begin
      player_out <= '0;
      keys       <= '0;
      old_tog    <= ps2_key[10];
    end else begin
      player_out <= merged;
      old_tog    <= ps2_key[10];
      if (ps2_key[10] != old_tog)
        keys <= (keys & ~kmask) | (kmask & {NBTN{ps2_key[9]}});
    end
  end

  // OSD settings survive RESET_L on purpose.
  always_ff @(posedge clk_sys) begin
    if (ioctl_wr && ioctl_index == IDX_DIP &&
        ioctl_addr[24:AW] == '0)
      dip_q[8*ioctl_addr[AW-1:0] +: 8] <= ioctl_dout;
    if (ioctl_wr && ioctl_index == IDX_MOD)
      mod_q <= ioctl_dout;
  end

  assign dip_out = dip_q;
  assign mod_id  = mod_q;
  assign osd_req = (db_count != '0) && joy_db[10] && joy_db[6];

  for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
    coin_stretch #(.COIN_HOLD(COIN_HOLD)) u_coin (
      .clk_sys  (clk_sys),
      .RESET_L  (RESET_L),
      .coin_in  (player_out[16*p+BTN_COIN]),
      .coin_out (coin_out[p])
    );
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed + randomized bench for arcade_input_mapper with
// an inline behavioural model of source merge and key state.
module tb_arcade_input_mapper;

  localparam int P = 2;
  localparam int DB = 8;
  localparam int HOLD = 50;

  logic          clk_sys = 1'b0;
  logic          RESET_L;
  logic [10:0]   ps2_key;
  logic [31:0]   joy_usb, joy_db;
  logic [1:0]    db_count;
  logic          ioctl_wr;
  logic [7:0]    ioctl_index;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic [31:0]   player_out;
  logic [1:0]    coin_out;
  logic [63:0]   dip_out;
  logic [7:0]    mod_id;
  logic          osd_req;

  int checks = 0;
  int failures = 0;

  arcade_input_mapper #(
    .PLAYERS(P), .DIP_BANKS(DB), .COIN_HOLD(HOLD)
  ) dut (
    .clk_sys(clk_sys), .RESET_L(RESET_L), .ps2_key(ps2_key),
    .joy_usb(joy_usb), .joy_db(joy_db), .db_count(db_count),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .player_out(player_out), .coin_out(coin_out),
    .dip_out(dip_out), .mod_id(mod_id), .osd_req(osd_req)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scancode table -> button index, -1 when unmapped.
  function automatic int key_idx(input logic [7:0] c);
    case (c)
      8'h74: return 0;
      8'h6B: return 1;
      8'h72: return 2;
      8'h75: return 3;
      8'h14: return 4;
      8'h11: return 5;
      8'h29: return 6;
      8'h12: return 7;
      8'h05, 8'h16: return 8;
      8'h06, 8'h1E: return 9;
      8'h2E, 8'h36: return 10;
      default: return -1;
    endcase
  endfunction

  // Players fill first from DB ports, remaining from USB in order.
  function automatic logic [31:0] model(input logic [31:0] db,
      input logic [31:0] usb, input int dbc, input logic [10:0] k);
    logic [15:0] src [2];
    int n, j;
    n = (dbc > P) ? P : dbc;
    j = 0;
    for (int i = 0; i < n; i++) begin src[j] = db[16*i +: 16]; j++; end
    for (int i = 0; j < P; i++) begin src[j] = usb[16*i +: 16]; j++; end
    src[0] = src[0] | {5'b0, k};
    return {src[1] & 16'h07FF, src[0] & 16'h07FF};
  endfunction

  logic        tog;
  logic [10:0] keys_m;
  logic [63:0] dip_m;
  logic [7:0]  codes [13];
  int          hi_cnt;

  task automatic key_ev(input logic pressed, input logic [7:0] c);
    tog = ~tog;
    ps2_key = {tog, pressed, 1'b0, c};
  endtask

  task automatic dip_wr(input logic [7:0] idx, input logic [24:0] a,
                        input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = a; ioctl_dout = d;
    step();
    ioctl_wr = 1'b0;
  endtask

  initial begin
    codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29,
              8'h12, 8'h05, 8'h16, 8'h06, 8'h1E, 8'h44};
    RESET_L = 1'b0; tog = 1'b1; ps2_key = {1'b1, 10'h000};
    joy_usb = '0; joy_db = '0; db_count = 2'd0;
    ioctl_wr = 1'b0; ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
    keys_m = '0; dip_m = '0;

    repeat (3) step();
    check("rst_player", player_out, 0);
    check("rst_coin", coin_out, 0);
    check("pwr_dip", dip_out, 0);
    check("pwr_mod", mod_id, 0);
    RESET_L = 1'b1;
    step(); step();
    check("no_spurious_key", player_out, 0);

    db_count = 2'd1; joy_db = 32'h0000_0008; joy_usb = 32'h0000_0001;
    step();
    check("merge_basic", player_out, 32'h0001_0008);
    joy_db = '0; joy_usb = '0;
    step();

    key_ev(1'b1, 8'h75);
    step();
    check("key_lat1", player_out[3], 1'b0);
    step();
    check("key_up_press", player_out, 32'h0000_0008);
    key_ev(1'b0, 8'h75);
    step(); step();
    check("key_up_release", player_out, 0);
    key_ev(1'b1, 8'h44);
    step(); step();
    check("key_unmapped", player_out, 0);

    // Randomized merge/keyboard phase; coin bits kept low here.
    for (int it = 0; it < 300; it++) begin
      logic [31:0] exp;
      logic        ev, pr;
      logic [7:0]  c;
      int          kb;
      joy_db   = $urandom() & 32'h03FF_03FF;
      joy_usb  = $urandom() & 32'h03FF_03FF;
      db_count = 2'($urandom_range(0, 3));
      ev = ($urandom_range(0, 2) == 0);
      pr = 1'($urandom());
      c  = codes[$urandom_range(0, 12)];
      if (ev) key_ev(pr, c);
      exp = model(joy_db, joy_usb, int'(db_count), keys_m);
      step();
      check("rand_merge", player_out, exp);
      if (ev) begin
        kb = key_idx(c);
        if (kb >= 0) keys_m[kb] = pr;
      end
    end

    joy_db = '0; joy_usb = '0; db_count = 2'd0;
    joy_db[10] = 1'b1; joy_db[6] = 1'b1;
    #1;
    check("osd_db0", osd_req, 1'b0);
    db_count = 2'd1;
    #1;
    check("osd_db1", osd_req, 1'b1);
    step();
    joy_db = '0; db_count = 2'd0;
    repeat (60) step();

    // Coin on player 1 from USB; second rise at cycle 20 ignored.
    joy_usb = 32'h0400_0000;
    hi_cnt = 0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      step();
      check("coin1_window", coin_out[1], (cyc >= 2 && cyc <= 51));
      check("coin0_idle", coin_out[0], 1'b0);
      if (coin_out[1]) hi_cnt++;
      joy_usb = ((cyc < 10) || (cyc >= 19 && cyc < 22))
                ? 32'h0400_0000 : 32'h0;
    end
    check("coin1_len", hi_cnt, HOLD);

    joy_usb = 32'h0400_0000;
    repeat (6) step();
    check("coin_mid", coin_out[1], 1'b1);
    RESET_L = 1'b0;
    step();
    check("coin_rst_drop", coin_out, 0);
    check("rst_player2", player_out, 0);
    joy_usb = '0;
    step();
    RESET_L = 1'b1;

    for (int a = 0; a < 8; a++) begin
      dip_wr(8'd254, 25'(a), 8'(8'h10 + a));
      dip_m[8*a +: 8] = 8'(8'h10 + a);
      check("dip_wr", dip_out, dip_m);
    end
    dip_wr(8'd254, 25'd8, 8'hFF);
    check("dip_addr8", dip_out, dip_m);
    dip_wr(8'd254, 25'h100, 8'hEE);
    check("dip_addr_hi", dip_out, dip_m);
    dip_wr(8'd253, 25'd0, 8'hAA);
    check("dip_bad_idx", dip_out, dip_m);
    dip_wr(8'd1, 25'd0, 8'h5A);
    check("mod_wr", mod_id, 8'h5A);
    RESET_L = 1'b0;
    step(); step();
    RESET_L = 1'b1;
    step();
    check("dip_keep", dip_out, 64'h1716_1514_1312_1110);
    check("mod_keep", mod_id, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
